// File: rtl/mem_lsu_if.sv
// Data-bus interface between the MEM-stage load/store unit and memory.
// The master drives the request side, the slave returns read data and ack.
interface mem_lsu_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      input  dbus_rdata, dbus_ack
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      output dbus_rdata, dbus_ack
   );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per load/store, big-endian lanes.
// Stalls the pipeline while busy; non-memory ops pass straight through to MEM/WB.
module mem_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       i_mem_waddr,
   input  logic             i_mem_we,
   input  logic [31:0]      i_mem_wdata,
   input  logic             i_mem_whilo,
   input  logic [31:0]      i_mem_hi,
   input  logic [31:0]      i_mem_lo,
   input  logic [3:0]       i_mem_op,
   input  logic [31:0]      i_mem_addr,
   input  logic [31:0]      i_mem_sdata,
   output logic [4:0]       o_wb_waddr,
   output logic             o_wb_we,
   output logic [31:0]      o_wb_wdata,
   output logic             o_wb_whilo,
   output logic [31:0]      o_wb_hi,
   output logic [31:0]      o_wb_lo,
   output logic             o_stall_req,
   output logic             o_exc_align,
   output logic             o_exc_bus,
   mem_lsu_if.master        dbus
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   function automatic logic [3:0] f_sel(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_LB, OP_LBU, OP_SB: f_sel = 4'b1000 >> off;
         OP_LH, OP_LHU, OP_SH: f_sel = off[1] ? 4'b0011 : 4'b1100;
         default:              f_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] f_store(input logic [3:0] op, input logic [31:0] d);
      case (op)
         OP_SB:   f_store = {4{d[7:0]}};
         OP_SH:   f_store = {2{d[15:0]}};
         default: f_store = d;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [3:0] op, input logic [1:0] off,
                                          input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = d[31:24];
         2'd1:    b = d[23:16];
         2'd2:    b = d[15:8];
         default: b = d[7:0];
      endcase
      h = off[1] ? d[15:0] : d[31:16];
      case (op)
         OP_LB:   f_load = {{24{b[7]}}, b};
         OP_LBU:  f_load = {24'd0, b};
         OP_LH:   f_load = {{16{h[15]}}, h};
         OP_LHU:  f_load = {16'd0, h};
         default: f_load = d;
      endcase
   endfunction

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_ldata;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_sel;
   logic        r_we;
   logic        r_tmo;
   logic        r_load;
   logic [3:0]  r_op;
   logic [1:0]  r_off;

   logic w_is_load, w_is_store, w_is_mem, w_misalign, w_idle, w_start;

   assign w_is_load  = (i_mem_op >= OP_LB) && (i_mem_op <= OP_LW);
   assign w_is_store = (i_mem_op >= OP_SB) && (i_mem_op <= OP_SW);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_misalign = (((i_mem_op == OP_LH) || (i_mem_op == OP_LHU) || (i_mem_op == OP_SH))
                        && i_mem_addr[0])
                     | (((i_mem_op == OP_LW) || (i_mem_op == OP_SW)) && (|i_mem_addr[1:0]));
   assign w_idle     = (r_state == S_IDLE);
   assign w_start    = w_idle & w_is_mem & ~w_misalign;

   // FSM: latch the access in IDLE, wait for ack or timeout in BUSY, present result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_ldata <= 32'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_sel   <= 4'd0;
         r_we    <= 1'b0;
         r_tmo   <= 1'b0;
         r_load  <= 1'b0;
         r_op    <= 4'd0;
         r_off   <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tmo <= 1'b0;
               if (w_start) begin
                  r_addr  <= {i_mem_addr[31:2], 2'b00};
                  r_sel   <= f_sel(i_mem_op, i_mem_addr[1:0]);
                  r_wdata <= f_store(i_mem_op, i_mem_sdata);
                  r_we    <= w_is_store;
                  r_load  <= w_is_load;
                  r_op    <= i_mem_op;
                  r_off   <= i_mem_addr[1:0];
                  r_cnt   <= 8'd0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (dbus.dbus_ack) begin
                  r_ldata <= f_load(r_op, r_off, dbus.dbus_rdata);
                  r_cnt   <= 8'd0;
                  r_state <= S_DONE;
               end else if (r_cnt == TMO_LAST) begin
                  r_tmo   <= 1'b1;
                  r_cnt   <= 8'd0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt   <= r_cnt + 8'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_wb_waddr  = rst ? 5'd0  : i_mem_waddr;
   assign o_wb_whilo  = rst ? 1'b0  : i_mem_whilo;
   assign o_wb_hi     = rst ? 32'd0 : i_mem_hi;
   assign o_wb_lo     = rst ? 32'd0 : i_mem_lo;
   assign o_stall_req = ~rst & (w_start | (r_state == S_BUSY));
   assign o_exc_align = ~rst & w_idle & w_is_mem & w_misalign;
   assign o_exc_bus   = ~rst & (r_state == S_DONE) & r_tmo;

   assign dbus.dbus_req   = ~rst & (r_state == S_BUSY);
   assign dbus.dbus_we    = ~rst & r_we;
   assign dbus.dbus_addr  = rst ? 32'd0 : r_addr;
   assign dbus.dbus_sel   = rst ? 4'd0  : r_sel;
   assign dbus.dbus_wdata = rst ? 32'd0 : r_wdata;

   // Write-back selection: memory ops write nothing until DONE, timeouts never write
   always_comb begin
      o_wb_we    = 1'b0;
      o_wb_wdata = 32'd0;
      if (rst) begin
         o_wb_we    = 1'b0;
         o_wb_wdata = 32'd0;
      end else begin
         o_wb_wdata = i_mem_wdata;
         case (r_state)
            S_IDLE: o_wb_we = i_mem_we & ~w_is_mem;
            S_BUSY: o_wb_we = 1'b0;
            S_DONE: begin
               if (r_tmo) begin
                  o_wb_we = 1'b0;
               end else begin
                  o_wb_we = i_mem_we;
                  if (r_load) begin
                     o_wb_wdata = r_ldata;
                  end else begin
                     o_wb_wdata = i_mem_wdata;
                  end
               end
            end
            default: o_wb_we = 1'b0;
         endcase
      end
   end

endmodule
